// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data access
module mem_port_arbiter #(
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT);
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t      state;
    logic        owner;
    logic [7:0]  tmo_cnt;
    logic [2:0]  starve_cnt;
    logic        dm_req;
    logic        starve_hit;
    logic        tmo_hit;
    logic [31:0] rsp_data;

    assign dm_req     = dm_read | dm_write;
    assign starve_hit = if_req && (starve_cnt == STARVE_LIM);
    assign tmo_hit    = (tmo_cnt + 8'd1) == TMO_LIM;
    // Stores report zero read data to the requester.
    assign rsp_data   = mem_we ? 32'd0 : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            tmo_cnt    <= 8'd0;
            starve_cnt <= 3'd0;
            if_ready   <= 1'b0;
            if_rdata   <= 32'd0;
            dm_ready   <= 1'b0;
            dm_rdata   <= 32'd0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= 8'd0;
                    if (dm_req && !starve_hit) begin
                        owner     <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= dm_write;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        state     <= ISSUE;
                        if (dm_read && dm_write) begin
                            bus_err <= 1'b1;
                        end
                        if (if_req) begin
                            starve_cnt <= (starve_cnt == STARVE_LIM) ? STARVE_LIM
                                                                     : starve_cnt + 3'd1;
                        end else begin
                            starve_cnt <= 3'd0;
                        end
                    end else if (if_req) begin
                        owner      <= 1'b0;
                        mem_en     <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= 32'd0;
                        starve_cnt <= 3'd0;
                        state      <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    mem_en <= 1'b0;
                    // A response in the final allowed cycle wins over the timeout.
                    if (mem_valid || tmo_hit) begin
                        state <= DONE;
                        if (!mem_valid) begin
                            bus_err <= 1'b1;
                        end
                        if (owner) begin
                            dm_ready <= 1'b1;
                            dm_rdata <= mem_valid ? rsp_data : 32'd0;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_valid ? rsp_data : 32'd0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        state   <= WAIT;
                    end
                end
                DONE: begin
                    if_ready <= 1'b0;
                    dm_ready <= 1'b0;
                    tmo_cnt  <= 8'd0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        dm_read = 1'b0;
    logic        dm_write = 1'b0;
    logic [31:0] dm_addr = 32'd0;
    logic [31:0] dm_wdata = 32'd0;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_valid = 1'b0;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TMO), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .bus_err(bus_err)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          mem_delay = 0;
    logic [31:0] rsp_data = 32'd0;
    logic        inj_valid = 1'b0;

    int          dly = 0;
    bit          pend = 0;
    int          en_cnt = 0;
    int          if_rdy_cnt = 0;
    int          dm_rdy_cnt = 0;
    logic [31:0] log_addr[$];
    logic        last_we = 1'b0;
    logic [31:0] last_wdata = 32'd0;

    // Memory responder: replies mem_delay cycles after the strobe; negative delay never replies.
    always @(negedge clk) begin
        mem_valid = inj_valid;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (mem_en) begin
                pend = 1;
                dly = mem_delay;
                en_cnt++;
                log_addr.push_back(mem_addr);
                last_we = mem_we;
                last_wdata = mem_wdata;
            end
            if (if_ready) if_rdy_cnt++;
            if (dm_ready) dm_rdy_cnt++;
            if (pend && dly >= 0) begin
                if (dly == 0) begin
                    mem_valid = 1'b1;
                    mem_rdata = rsp_data;
                    pend = 0;
                end else begin
                    dly--;
                end
            end
        end
    end

    typedef struct {
        bit          is_dm;
        bit          we;
        bit          both;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          delay;
        int          exp_lat;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
        if_addr = 32'd0; dm_addr = 32'd0; dm_wdata = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctl"}, {31'd0, if_ready | dm_ready | mem_en | mem_we | bus_err}, 32'd0);
        check({name, "_addr"}, mem_addr, 32'd0);
        check({name, "_wdata"}, mem_wdata, 32'd0);
        check({name, "_rdata"}, if_rdata | dm_rdata, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        bit          got;
        int          en0, ifr0, dmr0, lg0;
        logic [31:0] act_rdata;
        string       tag;
        tag = $sformatf("v%0d", idx);
        en0 = en_cnt; ifr0 = if_rdy_cnt; dmr0 = dm_rdy_cnt; lg0 = log_addr.size();
        @(negedge clk);
        mem_delay = v.delay;
        rsp_data = v.mdata;
        if (v.is_dm) begin
            dm_read = !v.we || v.both;
            dm_write = v.we;
            dm_addr = v.addr;
            dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1;
            if_addr = v.addr;
        end
        lat = 0;
        got = 0;
        act_rdata = 32'd0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                if_addr = 32'hFFFF_FFFF; dm_addr = 32'hFFFF_FFFF; dm_wdata = 32'hFFFF_FFFF;
            end
            if (v.is_dm ? dm_ready : if_ready) begin
                got = 1;
                act_rdata = v.is_dm ? dm_rdata : if_rdata;
                if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_ready_timeout: no ready within 40 cycles", tag);
            if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
        end else begin
            check({tag, "_latency"}, lat, v.exp_lat);
            check({tag, "_rdata"}, act_rdata, v.exp_rdata);
        end
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_en_count"}, en_cnt - en0, 1);
        if (log_addr.size() > lg0) check({tag, "_mem_addr"}, log_addr[lg0], v.addr);
        check({tag, "_mem_we"}, {31'd0, last_we}, {31'd0, v.is_dm & v.we});
        check({tag, "_mem_wdata"}, last_wdata, v.is_dm ? v.wdata : 32'd0);
        check({tag, "_own_ready_cnt"}, v.is_dm ? dm_rdy_cnt - dmr0 : if_rdy_cnt - ifr0, 1);
        check({tag, "_other_ready_cnt"}, v.is_dm ? if_rdy_cnt - ifr0 : dm_rdy_cnt - dmr0, 0);
        check({tag, "_bus_err"}, {31'd0, bus_err}, {31'd0, v.exp_err});
        if (v.exp_err) begin
            repeat (5) @(negedge clk);
            check({tag, "_bus_err_sticky"}, {31'd0, bus_err}, 32'd1);
        end
    endtask

    task automatic run_mix(input int n_dm, input int n_if, input string tag);
        int dm_done, if_done;
        dm_done = 0;
        if_done = 0;
        @(negedge clk);
        mem_delay = 0;
        rsp_data = 32'h0BAD_F00D;
        if_addr = 32'h40;
        dm_addr = 32'h100;
        if_req = n_if > 0;
        dm_read = n_dm > 0;
        for (int c = 0; c < 300 && (dm_done < n_dm || if_done < n_if); c++) begin
            @(posedge clk);
            @(negedge clk);
            if (dm_ready) begin
                check({tag, "_dm_rdata"}, dm_rdata, 32'h0BAD_F00D);
                dm_done++;
                if (dm_done >= n_dm) dm_read = 1'b0;
            end
            if (if_ready) begin
                check({tag, "_if_rdata"}, if_rdata, 32'h0BAD_F00D);
                if_done++;
                if (if_done >= n_if) if_req = 1'b0;
            end
        end
        check({tag, "_dm_done"}, dm_done, n_dm);
        check({tag, "_if_done"}, if_done, n_if);
        if_req = 1'b0;
        dm_read = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic [31:0] exp_order[11];
    int          en_base;
    int          dmr_base;
    int          ifr_base;

    initial begin
        vecs[0] = '{0, 0, 0, 32'h40,  32'h0,        32'h0050_0093, 2,  4, 32'h0050_0093, 0};
        vecs[1] = '{1, 0, 0, 32'h100, 32'h0,        32'h1122_3344, 0,  2, 32'h1122_3344, 0};
        vecs[2] = '{1, 1, 0, 32'h200, 32'hDEADBEEF, 32'hFFFF_FFFF, 1,  3, 32'h0,         0};
        vecs[3] = '{0, 0, 0, 32'h44,  32'h0,        32'hAAAA_5555, -1, 9, 32'h0,         1};
        vecs[4] = '{1, 1, 1, 32'h300, 32'h1234_5678, 32'hCAFE_F00D, 0, 2, 32'h0,         1};
        vecs[5] = '{1, 0, 0, 32'h104, 32'h0,        32'h7777_7777, -1, 9, 32'h0,         1};
        vecs[6] = '{1, 0, 0, 32'h108, 32'h0,        32'h1357_9BDF, 7,  9, 32'h1357_9BDF, 0};

        apply_reset();
        #1;
        check_zero("reset");

        for (int i = 0; i < 7; i++) begin
            apply_reset();
            run_vec(vecs[i], i);
        end

        // Simultaneous requests: data first, then fetch.
        apply_reset();
        en_base = log_addr.size();
        run_mix(1, 1, "simul");
        check("simul_en_count", log_addr.size() - en_base, 2);
        if (log_addr.size() >= en_base + 2) begin
            check("simul_first", log_addr[en_base], 32'h100);
            check("simul_second", log_addr[en_base + 1], 32'h40);
        end

        // Starvation: fetch forced after four consecutive data grants, counter then restarts.
        apply_reset();
        en_base = log_addr.size();
        run_mix(9, 2, "starve");
        for (int i = 0; i < 11; i++) exp_order[i] = 32'h100;
        exp_order[4] = 32'h40;
        exp_order[9] = 32'h40;
        check("starve_en_count", log_addr.size() - en_base, 11);
        for (int i = 0; i < 11; i++) begin
            if (log_addr.size() > en_base + i)
                check($sformatf("starve_grant%0d", i), log_addr[en_base + i], exp_order[i]);
        end

        // Reset while waiting on memory, then a stray response.
        apply_reset();
        @(negedge clk);
        mem_delay = -1;
        dm_read = 1'b1;
        dm_addr = 32'h180;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("midwait_reset");
        dm_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en_base = en_cnt;
        dmr_base = dm_rdy_cnt;
        ifr_base = if_rdy_cnt;
        @(posedge clk);
        #2;
        inj_valid = 1'b1;
        @(posedge clk);
        #2;
        inj_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("late_valid_ready", (dm_rdy_cnt - dmr_base) + (if_rdy_cnt - ifr_base), 0);
        check("late_valid_en", en_cnt - en_base, 0);
        check("late_valid_bus_err", {31'd0, bus_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
